// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row drive, 2-flop column sync, debounce, one event per press.
// Define KEYPAD_REPEAT_EN to add typematic auto-repeat (REPEAT_START / REPEAT_PERIOD).
module keypad_scanner #(
    parameter int unsigned NROWS         = 4,
    parameter int unsigned NCOLS         = 4,
    parameter int unsigned SCAN_DWELL    = 4,
    parameter int unsigned DEBOUNCE      = 10,
    parameter int unsigned RELEASE_DELAY = 20
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_START  = 500,
    parameter int unsigned REPEAT_PERIOD = 100
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NCOLS-1:0]                  cols,
    output logic [NROWS-1:0]                  rows,
    output logic                              key_valid,
    output logic [$clog2(NROWS)-1:0]          key_row,
    output logic [$clog2(NCOLS)-1:0]          key_col,
    output logic [$clog2(NROWS*NCOLS)-1:0]    key_code,
    output logic                              held,
    output logic                              scanning
);

    localparam int unsigned RW = $clog2(NROWS);
    localparam int unsigned CW = $clog2(NCOLS);
    localparam int unsigned KW = $clog2(NROWS * NCOLS);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StHold} state_e;

    state_e            state_q, state_d;
    logic [NCOLS-1:0]  sync1_q, csync_q;
    logic [NCOLS-1:0]  pat_q, pat_d;
    logic [RW-1:0]     row_q, row_d, row_next;
    logic [NROWS-1:0]  rows_q, rows_d;
    logic [31:0]       dwell_q, dwell_d;
    logic [31:0]       deb_q, deb_d;
    logic [31:0]       rel_q, rel_d;
    logic              key_valid_q, key_valid_d;
    logic [RW-1:0]     key_row_q, key_row_d;
    logic [CW-1:0]     key_col_q, key_col_d;
    logic [KW-1:0]     key_code_q, key_code_d;
    logic              held_q, held_d;
    logic [CW-1:0]     pat_col;
    logic              pat_multi;
`ifdef KEYPAD_REPEAT_EN
    logic [31:0]       rpt_q, rpt_d;
    logic              rpt_on_q, rpt_on_d;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [CW-1:0] col_index(input logic [NCOLS-1:0] p);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NCOLS; i++) begin
            if (p[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    assign row_next  = (row_q == RW'(NROWS - 1)) ? '0 : row_q + 1'b1;
    assign pat_col   = col_index(pat_q);
    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign pat_multi = |(pat_q & (pat_q - 1'b1));

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        row_d       = row_q;
        rows_d      = rows_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        rel_d       = rel_q;
        key_valid_d = 1'b0;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_code_d  = key_code_q;
        held_d      = held_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_on_d    = rpt_on_q;
`endif
        unique case (state_q)
            StScan: begin
                if (dwell_q >= SCAN_DWELL - 1) begin
                    dwell_d = '0;
                    if (csync_q == '0) begin
                        row_d  = row_next;
                        rows_d = NROWS'(1) << row_next;
                    end else begin
                        pat_d   = csync_q;
                        deb_d   = '0;
                        state_d = StDebounce;
                    end
                end else begin
                    dwell_d = sat_inc(dwell_q);
                end
            end
            StDebounce: begin
                if (csync_q == pat_q) begin
                    deb_d = sat_inc(deb_q);
                    if (deb_d >= DEBOUNCE) begin
                        deb_d = '0;
                        rel_d = '0;
                        if (pat_multi) begin
                            // Ambiguous chord: swallow it and just wait for release.
                            held_d  = 1'b0;
                            state_d = StHold;
                        end else begin
                            key_valid_d = 1'b1;
                            key_row_d   = row_q;
                            key_col_d   = pat_col;
                            key_code_d  = KW'(int'(row_q) * NCOLS + int'(pat_col));
                            held_d      = 1'b1;
                            state_d     = StPressed;
                        end
                    end
                end else if (csync_q != '0) begin
                    pat_d = csync_q;
                    deb_d = '0;
                end else begin
                    deb_d   = '0;
                    dwell_d = '0;
                    row_d   = row_next;
                    rows_d  = NROWS'(1) << row_next;
                    state_d = StScan;
                end
            end
            StPressed: begin
                rel_d   = '0;
                state_d = StHold;
`ifdef KEYPAD_REPEAT_EN
                // Counts cycles since the accept pulse, which was this cycle.
                rpt_d    = 32'd1;
                rpt_on_d = 1'b0;
`endif
            end
            StHold: begin
                if (csync_q == '0) begin
                    rel_d = sat_inc(rel_q);
                    if (rel_d >= RELEASE_DELAY) begin
                        rel_d   = '0;
                        held_d  = 1'b0;
                        dwell_d = '0;
                        row_d   = row_next;
                        rows_d  = NROWS'(1) << row_next;
                        state_d = StScan;
                    end
                end else begin
                    rel_d = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                if (held_q && (csync_q == pat_q)) begin
                    rpt_d = sat_inc(rpt_q);
                    if (rpt_d >= (rpt_on_q ? REPEAT_PERIOD : REPEAT_START)) begin
                        key_valid_d = 1'b1;
                        rpt_d       = '0;
                        rpt_on_d    = 1'b1;
                    end
                end else begin
                    rpt_d    = '0;
                    rpt_on_d = 1'b0;
                end
`endif
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StScan;
            sync1_q     <= '0;
            csync_q     <= '0;
            pat_q       <= '0;
            row_q       <= '0;
            rows_q      <= NROWS'(1);
            dwell_q     <= '0;
            deb_q       <= '0;
            rel_q       <= '0;
            key_valid_q <= 1'b0;
            key_row_q   <= '0;
            key_col_q   <= '0;
            key_code_q  <= '0;
            held_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
            rpt_on_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= cols;
            csync_q     <= sync1_q;
            pat_q       <= pat_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            rel_q       <= rel_d;
            key_valid_q <= key_valid_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_code_q  <= key_code_d;
            held_q      <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
            rpt_on_q    <= rpt_on_d;
`endif
        end
    end

    assign rows      = rows_q;
    assign key_valid = key_valid_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_code  = key_code_q;
    assign held      = held_q;
    assign scanning  = (state_q == StScan);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model answers the row drive, expected events
// are queued at press time and matched against each key_valid pulse.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic [3:0] key_code;
    logic       held;
    logic       scanning;

    logic       key_en = 1'b0;
    int         key_r = 0;
    logic [3:0] key_pat = '0;

    typedef struct {
        int row;
        int col;
        int code;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   ev_t[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   vld_cnt = 0;
    int   cyc = 0;

    keypad_scanner #(
        .NROWS        (4),
        .NCOLS        (4),
        .SCAN_DWELL   (4),
        .DEBOUNCE     (4),
        .RELEASE_DELAY(8)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_START (20),
        .REPEAT_PERIOD(10)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cols     (cols),
        .rows     (rows),
        .key_valid(key_valid),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_code (key_code),
        .held     (held),
        .scanning (scanning)
    );

    always #5 clk = ~clk;

    // Pressed switch connects its row to the pattern's columns only while that row is driven.
    always_comb cols = (key_en && rows[key_r]) ? key_pat : 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            vld_cnt++;
            ev_t.push_back(cyc);
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(key_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("ev_key_row", 32'(key_row), e.row);
                chk("ev_key_col", 32'(key_col), e.col);
                chk("ev_key_code", 32'(key_code), e.code);
                chk("ev_held", 32'(held), 1);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_vld(input string tag, input int target);
        for (int i = 0; i < 200; i++) begin
            if (vld_cnt >= target) break;
            tick(1);
        end
        chk(tag, vld_cnt, target);
    endtask

    task automatic press(input int r, input logic [3:0] p);
        key_r   = r;
        key_pat = p;
        key_en  = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_rows;
        int         base;

        // Reset state and free-running scan
        tick(3);
        chk("rst_rows", 32'(rows), 1);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_held", 32'(held), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_scanning", 32'(scanning), 1);
        reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            exp_rows = 4'b0001 << ((k / 4) % 4);
            chk($sformatf("scan_rows_%0d", k), 32'(rows), 32'(exp_rows));
            tick(1);
        end

        // Single key at row 1, column 2
        press(1, 4'b0100);
        sb.push_back('{row: 1, col: 2, code: 6});
        wait_vld("press1_event", 1);
        tick(1);
        chk("press1_held", 32'(held), 1);
        chk("press1_scanning", 32'(scanning), 0);
        key_en = 1'b0;
        tick(9);
        chk("rel1_held_still", 32'(held), 1);
        tick(1);
        chk("rel1_held_low", 32'(held), 0);
        chk("rel1_next_row", 32'(rows), 32'(4'b0100));
        chk("rel1_count", vld_cnt, 1);

        // Bouncing contact on row 2, column 2, then stable
        key_r   = 2;
        key_pat = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            key_en = ~key_en;
            tick(2);
        end
        key_en = 1'b0;
        tick(4);
        chk("bounce_no_event", vld_cnt, 1);
        sb.push_back('{row: 2, col: 2, code: 10});
        key_en = 1'b1;
        wait_vld("bounce_event", 2);
        key_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (held == 1'b0) break;
            tick(1);
        end
        chk("bounce_released", 32'(held), 0);

        // Two keys together in row 3: no event, wait for release
        press(3, 4'b0011);
        for (int i = 0; i < 80; i++) begin
            if (scanning == 1'b0) break;
            tick(1);
        end
        tick(20);
        chk("multi_no_event", vld_cnt, 2);
        chk("multi_held", 32'(held), 0);
        chk("multi_frozen", 32'(scanning), 0);
        key_en = 1'b0;
        tick(9);
        chk("multi_still_hold", 32'(scanning), 0);
        tick(1);
        chk("multi_resume", 32'(scanning), 1);
        chk("multi_wrap_row", 32'(rows), 1);

        // Reset while a key is held
        press(0, 4'b1000);
        sb.push_back('{row: 0, col: 3, code: 3});
        wait_vld("rst_press_event", 3);
        tick(2);
        reset  = 1'b0;
        key_en = 1'b0;
        tick(1);
        chk("midrst_rows", 32'(rows), 1);
        chk("midrst_held", 32'(held), 0);
        chk("midrst_valid", 32'(key_valid), 0);
        chk("midrst_code", 32'(key_code), 0);
        tick(2);
        reset = 1'b1;
        tick(40);
        chk("midrst_no_event", vld_cnt, 3);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat on row 3, column 1
        base = ev_t.size();
        for (int i = 0; i < 4; i++) sb.push_back('{row: 3, col: 1, code: 13});
        press(3, 4'b0010);
        wait_vld("rpt_first", 4);
        tick(45);
        key_en = 1'b0;
        tick(20);
        chk("rpt_count", vld_cnt, 7);
        if (ev_t.size() >= base + 4) begin
            chk("rpt_gap_start", ev_t[base+1] - ev_t[base], 20);
            chk("rpt_gap_p1", ev_t[base+2] - ev_t[base+1], 10);
            chk("rpt_gap_p2", ev_t[base+3] - ev_t[base+2], 10);
        end
`else
        base = 0;
`endif

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
